// File: rtl/addsub_pkg.sv
// Shared definitions for the byte-serial add/subtract unit: controller state
// encoding, default operand size and a helper for the byte-index width.
package addsub_pkg;

  // Default operand width in bytes; legal range is 2..8.
  localparam int NBYTES_DEFAULT = 4;

  // Width of the shared arithmetic slice.
  localparam int BYTE_W = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bits needed to address one byte of an nbytes-wide operand.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One 8-bit add slice: sum = x + y + cin. Besides the carry out of bit 7 it
// also exposes the carry into bit 7, so the caller can form signed overflow
// on the top byte. Purely combinational.
module addsub_slice
  import addsub_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  input  logic [BYTE_W-1:0] y,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              c7,
  output logic              cout
);

  // Low seven bits plus carry-in; bit 7 of this partial sum is the carry
  // that enters the MSB position.
  logic [BYTE_W-1:0] low_sum;
  // MSB position: x[7] + y[7] + c7, giving the sum MSB and the carry out.
  logic [1:0]        high_sum;

  assign low_sum  = {1'b0, x[BYTE_W-2:0]} + {1'b0, y[BYTE_W-2:0]} + {{(BYTE_W-1){1'b0}}, cin};
  assign c7       = low_sum[BYTE_W-1];
  assign high_sum = {1'b0, x[BYTE_W-1]} + {1'b0, y[BYTE_W-1]} + {1'b0, c7};

  assign sum  = {high_sum[0], low_sum[BYTE_W-2:0]};
  assign cout = high_sum[1];

endmodule

// File: rtl/addsub_seq.sv
// Byte-serial two's-complement adder/subtractor. A request is latched in
// IDLE, one byte per cycle is processed through a single shared 8-bit slice
// in RUN (LSB first, carry rippling through carry_reg), and the result with
// carry/overflow/zero flags is held in DONE until the consumer takes it.
// Subtraction is a + ~b + 1: the carry register is preset to op on accept.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  ovf,
  output logic                  zero,
  output logic                  busy
);

  localparam int KW = idx_width(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  // Controller state
  state_t state_reg;
  state_t state_next;

  // Decoded controls from the current state
  logic accept;     // request handshake this cycle
  logic step;       // a byte is processed this cycle
  logic last_step;  // the top byte is processed this cycle

  // Byte index and inter-byte carry
  logic [KW-1:0] k_reg;
  logic          carry_reg;

  // Latched request
  logic              op_reg;
  logic [BYTE_W-1:0] a_byte_reg [NBYTES];
  logic [BYTE_W-1:0] b_byte_reg [NBYTES];

  // Held response
  logic [BYTE_W-1:0] result_byte_reg [NBYTES];
  logic              carry_flag_reg;
  logic              ovf_reg;

  // Shared slice connections
  logic [BYTE_W-1:0] slice_x;
  logic [BYTE_W-1:0] slice_y;
  logic [BYTE_W-1:0] slice_sum;
  logic              slice_c7;
  logic              slice_cout;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake/status decode
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (k_reg == K_LAST) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand byte k feeds the slice; b is inverted for subtraction.
  assign slice_x = a_byte_reg[k_reg];
  assign slice_y = op_reg ? ~b_byte_reg[k_reg] : b_byte_reg[k_reg];

  addsub_slice u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .c7   (slice_c7),
    .cout (slice_cout)
  );

  // Byte index, ripple carry, latched op and final flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg          <= '0;
      carry_reg      <= 1'b0;
      op_reg         <= 1'b0;
      carry_flag_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else if (accept) begin
      k_reg     <= '0;
      carry_reg <= op;
      op_reg    <= op;
    end else if (step) begin
      k_reg     <= k_reg + K_ONE;
      carry_reg <= slice_cout;
      if (last_step) begin
        carry_flag_reg <= slice_cout;
        ovf_reg        <= slice_c7 ^ slice_cout;
      end
    end
  end

  // Per-byte operand capture and result write-back
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam logic [KW-1:0] K_MINE = KW'(gi);

      // Capture this byte of both operands on acceptance only
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_byte_reg[gi] <= '0;
          b_byte_reg[gi] <= '0;
        end else if (accept) begin
          a_byte_reg[gi] <= a[gi*BYTE_W +: BYTE_W];
          b_byte_reg[gi] <= b[gi*BYTE_W +: BYTE_W];
        end
      end

      // Write this result byte in the RUN cycle that processes it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          result_byte_reg[gi] <= '0;
        end else if (step && (k_reg == K_MINE)) begin
          result_byte_reg[gi] <= slice_sum;
        end
      end

      assign result[gi*BYTE_W +: BYTE_W] = result_byte_reg[gi];
    end
  endgenerate

  assign carry = carry_flag_reg;
  assign ovf   = ovf_reg;
  // Zero flag only means something while a response is presented.
  assign zero  = rsp_valid & ~(|result);

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq with NBYTES=4: reset state, add/sub corner
// cases, flag behaviour, response back-pressure and reset during RUN.
module tb_addsub_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request on a falling edge, hold it across one rising edge,
  // then scramble the inputs to show they are ignored after acceptance.
  task automatic accept_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = ~o;
    a  = ~x;
    b  = x ^ y ^ 32'h5A5A_A5A5;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Count rising edges from acceptance until rsp_valid; bounded.
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NB));
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] er,
                           input logic ec, input logic eo, input logic ez);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_result"},    64'(result),    64'(er));
    check({tag, "_carry"},     64'(carry),     64'(ec));
    check({tag, "_ovf"},       64'(ovf),       64'(eo));
    check({tag, "_zero"},      64'(zero),      64'(ez));
    $display("txn %s: result=%h carry=%b ovf=%b zero=%b", tag, result, carry, ovf, zero);
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_valid_after_take"}, 64'(rsp_valid), 64'd0);
    check({tag, "_req_ready_after_take"}, 64'(req_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er,
                        input logic ec, input logic eo, input logic ez);
    accept_op(o, x, y);
    wait_rsp(tag);
    check_rsp(tag, er, ec, eo, ez);
    finish_rsp(tag);
  endtask

  initial begin
    int seen;

    // Reset state while rst is high
    #12;
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_carry",     64'(carry),     64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_zero",      64'(zero),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Arithmetic corner cases
    run_op("add_ff_1",    1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("sub_0_1",     1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_eq",      1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",     1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",     1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Back-pressure in DONE with a pending request and toggling operands
    accept_op(1'b0, 32'h0000_0005, 32'h0000_0006);
    wait_rsp("hold");
    check_rsp("hold", 32'h0000_000B, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = ~op;
      @(posedge clk);
      #1;
      check("hold_result",    64'(result),    64'h0000_000B);
      check("hold_flags",     64'({carry, ovf, zero}), 64'd0);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    op = 1'b0;
    a  = 32'd10;
    b  = 32'd20;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("handshake_no_accept_busy", 64'(busy),      64'd0);
    check("handshake_req_ready",      64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    op = 1'b1;
    check("second_accept_busy", 64'(busy), 64'd1);
    wait_rsp("second");
    check_rsp("second", 32'd30, 1'b0, 1'b0, 1'b0);
    finish_rsp("second");

    // Reset in RUN with k=2 abandons the operation
    accept_op(1'b0, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) seen++;
    end
    check("mid_rst_no_response", 64'(seen), 64'd0);
    $display("txn mid_rst: operation abandoned");
    run_op("add_3_4", 1'b0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning operand width in bytes (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning a request is presented.
REQ-005 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 SHALL have port op, input, 1, meaning operation select: 0 = a+b, 1 = a-b.
REQ-007 SHALL have ports a and b, input, 8*NBYTES each, meaning two's-complement operands.
REQ-008 SHALL have port rsp_valid, output, 1, meaning the result and flags are valid.
REQ-009 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-010 SHALL have port result, output, 8*NBYTES, meaning the sum or difference.
REQ-011 SHALL have port carry, output, 1, meaning MSB carry-out (for sub: 1 = no borrow).
REQ-012 SHALL have port ovf, output, 1, meaning signed overflow.
REQ-013 SHALL have port zero, output, 1, meaning result equals 0.
REQ-014 SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 SHALL drive req_ready = 1 only in IDLE.
REQ-017 SHALL, on an edge with req_valid&req_ready, latch a, b and op, clear byte index k to 0, preset the carry register to op, and enter RUN.
REQ-018 SHALL, in each RUN cycle, compute byte k with one shared 8-bit slice: a[k] + (op ? ~b[k] : b[k]) + carry_reg.
REQ-019 SHALL, at the end of that RUN cycle, write the slice sum into result byte k, load the slice carry-out into carry_reg, and increment k.
REQ-020 SHALL, at the edge where k = NBYTES-1, capture carry from the slice carry-out and ovf = (carry into bit 7) XOR (carry out of bit 7) of that top slice, then enter DONE.
REQ-021 SHALL assert rsp_valid exactly NBYTES cycles after the acceptance edge, and only in DONE.
REQ-022 SHALL hold result, carry, ovf and zero stable while rsp_valid=1 and rsp_ready=0.
REQ-023 SHALL, on an edge in DONE with rsp_ready=1, return to IDLE; a request is accepted no earlier than the following edge.
REQ-024 SHALL derive zero combinationally from the held result and qualify it by rsp_valid.
REQ-025 SHALL ignore changes on a, b and op after acceptance.
REQ-026 SHALL ignore req_valid outside IDLE.
REQ-027 SHALL wrap arithmetic modulo 2^(8*NBYTES); the carry out of the MSB is not carried into the next request.
REQ-028 SHALL give a throughput of one operation per NBYTES+2 cycles when rsp_ready is held at 1.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, k=0, carry_reg=0, result=0, carry=0, ovf=0, rsp_valid=0 and busy=0, with req_ready=1 after release.
REQ-030 SHALL, on rst asserted in RUN or DONE, abandon the operation and emit no response.

Structure
REQ-031 SHALL place the state encoding (IDLE, RUN, DONE) and the NBYTES default in a shared package addsub_pkg.
REQ-032 SHALL instantiate exactly one sub-module, addsub_slice: 8-bit x, y, cin in; sum, c7 (carry into bit 7) and cout out; purely combinational.
REQ-033 SHALL contain no arithmetic wider than 8 bits outside addsub_slice, apart from the index counter.

Verification (NBYTES=4)
REQ-034 SHALL cover: add 0x000000FF + 0x00000001 -> result 0x00000100, carry 0, ovf 0, zero 0; rsp_valid 4 cycles after accept.
REQ-035 SHALL cover: sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, carry 0, ovf 0; and sub 0x12345678 - 0x12345678 -> result 0, carry 1, zero 1.
REQ-036 SHALL cover: add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf 1, carry 0; and sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, ovf 1, carry 1.
REQ-037 SHALL cover: rsp_ready low for 5 cycles in DONE with req_valid high and operands toggling -> outputs stable, req_ready 0, no second accept until 1 cycle after the handshake.
REQ-038 SHALL cover: rst pulsed during RUN at k=2 -> busy 0 and rsp_valid 0 immediately, no response; a following add 3+4 -> result 7 with correct latency.
